// File: rtl/program_sequencer.sv
// program_sequencer: picoMIPS PC/ROM addressing and instruction decode,
// with handshake-switch waits and multi-cycle multiply stalls.
module program_sequencer #(
    parameter int N          = 8,
    parameter int O_SIZE     = 3,
    parameter int R_SIZE     = 3,
    parameter int P_SIZE     = 5,
    parameter int MUL_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       nReset,
    output logic [P_SIZE-1:0]          prog_addr,
    input  logic [O_SIZE+R_SIZE+N-1:0] prog_data,
    input  logic                       sw_handshake,
    output logic                       write_reg,
    output logic [1:0]                 alu_func,
    output logic                       alu_immediate,
    output logic                       imm_switches,
    output logic [R_SIZE-1:0]          op_d,
    output logic [N-1:0]               op_s,
    output logic [P_SIZE-1:0]          display_pc,
    output logic [15:0]                retired
);
    localparam int C_W = MUL_CYCLES > 2 ? $clog2(MUL_CYCLES) : 1;
    localparam logic [O_SIZE-1:0] OP_ADD   = O_SIZE'(1);
    localparam logic [O_SIZE-1:0] OP_ADDI  = O_SIZE'(2);
    localparam logic [O_SIZE-1:0] OP_MUL   = O_SIZE'(3);
    localparam logic [O_SIZE-1:0] OP_LDSW  = O_SIZE'(4);
    localparam logic [O_SIZE-1:0] OP_WAITH = O_SIZE'(5);
    localparam logic [O_SIZE-1:0] OP_WAITL = O_SIZE'(6);
    localparam logic [O_SIZE-1:0] OP_JMP   = O_SIZE'(7);

    typedef enum logic {RUN, MUL_STALL} state_t;

    state_t            state;
    logic              run_en;
    logic [C_W-1:0]    cnt;
    logic              hs_meta;
    logic              hs_sync;
    logic [P_SIZE-1:0] pc;
    logic [O_SIZE-1:0] op;
    logic              is_mul;
    logic              mul_last;
    logic              advance;

    assign op         = prog_data[O_SIZE+R_SIZE+N-1 -: O_SIZE];
    assign op_d       = prog_data[R_SIZE+N-1 -: R_SIZE];
    assign op_s       = prog_data[N-1:0];
    assign prog_addr  = pc;
    assign display_pc = pc;

    // PC is held during a stall, so the ROM keeps presenting the MUL word
    always_comb begin
        is_mul        = state == MUL_STALL || op == OP_MUL;
        mul_last      = state == MUL_STALL ? cnt == '0 : MUL_CYCLES == 1;
        advance       = run_en && (is_mul ? mul_last : op == OP_WAITH ? hs_sync : op == OP_WAITL ? !hs_sync : 1'b1);
        write_reg     = run_en && (is_mul ? mul_last : op == OP_ADD || op == OP_ADDI || op == OP_LDSW);
        alu_func      = !run_en ? 2'b00 : is_mul ? 2'b01 : op == OP_LDSW ? 2'b10 : 2'b00;
        alu_immediate = run_en && (is_mul || op == OP_ADDI);
        imm_switches  = run_en && op == OP_LDSW;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state   <= RUN;
            run_en  <= 1'b0;
            cnt     <= '0;
            hs_meta <= 1'b0;
            hs_sync <= 1'b0;
            pc      <= '0;
            retired <= '0;
        end else begin
            hs_meta <= sw_handshake;
            hs_sync <= hs_meta;
            run_en  <= 1'b1;
            if (advance) begin
                pc    <= op == OP_JMP ? prog_data[P_SIZE-1:0] : pc + 1'b1;
                state <= RUN;
                if (retired != 16'hFFFF) retired <= retired + 1'b1;
            end else if (run_en && state == RUN && is_mul) begin
                state <= MUL_STALL;
                cnt   <= C_W'(MUL_CYCLES > 1 ? MUL_CYCLES - 2 : 0);
            end else if (state == MUL_STALL) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed and randomized checks of program_sequencer
// against a cycle-level model of the instruction-set rules.
module tb_program_sequencer;
    localparam int MC = 4;

    logic        clk = 0;
    logic        nReset = 1;
    logic        sw_handshake = 0;
    logic [4:0]  prog_addr, display_pc;
    logic [13:0] prog_data;
    logic        write_reg, alu_immediate, imm_switches;
    logic [1:0]  alu_func;
    logic [2:0]  op_d;
    logic [7:0]  op_s;
    logic [15:0] retired;
    logic [13:0] rom [32];
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 0;

    // behavioural model: PC, running flag, cycles spent in current MUL, retire count
    logic [4:0]  m_pc = 0;
    bit          m_run = 0;
    int          m_el = 0;
    int          m_ret = 0;
    bit          h1 = 0, h2 = 0;

    program_sequencer dut (
        .clk(clk), .nReset(nReset), .prog_addr(prog_addr), .prog_data(prog_data),
        .sw_handshake(sw_handshake), .write_reg(write_reg), .alu_func(alu_func),
        .alu_immediate(alu_immediate), .imm_switches(imm_switches), .op_d(op_d),
        .op_s(op_s), .display_pc(display_pc), .retired(retired)
    );

    always #5 clk = ~clk;
    assign prog_data = rom[prog_addr];

    function automatic logic [13:0] ins(int op, int rd, int imm);
        return {3'(op), 3'(rd), 8'(imm)};
    endfunction

    function automatic int m_op();
        return int'(rom[m_pc][13:11]);
    endfunction

    function automatic bit m_adv();
        int o = m_op();
        if (!m_run) return 0;
        if (o == 3) return m_el == MC - 1;
        if (o == 5) return h2;
        if (o == 6) return !h2;
        return 1;
    endfunction

    function automatic logic [4:0] m_ctl();
        int o = m_op();
        bit wr;
        int af;
        if (!m_run) return 5'b0;
        wr = o == 1 || o == 2 || o == 4 || (o == 3 && m_el == MC - 1);
        af = o == 3 ? 1 : o == 4 ? 2 : 0;
        return {wr, 2'(af), o == 2 || o == 3, o == 4};
    endfunction

    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            m_pc <= 0; m_run <= 0; m_el <= 0; m_ret <= 0; h1 <= 0; h2 <= 0;
        end else begin
            h1 <= sw_handshake;
            h2 <= h1;
            m_run <= 1;
            if (m_adv()) begin
                m_pc  <= m_op() == 7 ? rom[m_pc][4:0] : m_pc + 5'd1;
                m_el  <= 0;
                m_ret <= m_ret == 65535 ? 65535 : m_ret + 1;
            end else if (m_run && m_op() == 3) begin
                m_el <= m_el + 1;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", 32'(prog_addr), 32'(m_pc));
            chk("display_pc", 32'(display_pc), 32'(m_pc));
            chk("retired", 32'(retired), m_ret);
            chk("ctl{wr,func,imm,sw}", 32'({write_reg, alu_func, alu_immediate, imm_switches}), 32'(m_ctl()));
            chk("op_d", 32'(op_d), 32'(rom[m_pc][10:8]));
            chk("op_s", 32'(op_s), 32'(rom[m_pc][7:0]));
        end
    end

    task automatic rst_on();
        @(negedge clk); #1 nReset = 0;
        for (int i = 0; i < 32; i++) rom[i] = ins(0, 0, 0);
    endtask

    task automatic rst_off();
        @(negedge clk); #1 nReset = 1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = '0;
        #1 nReset = 0;
        chk_en = 1;
        // reset release with ADDI r1,5
        rst_on(); rom[0] = ins(2, 1, 5); rst_off();
        #1 chk("dead_cycle_wr", 32'(write_reg), 0);
        @(negedge clk);
        chk("addi_wr", 32'(write_reg), 1);
        chk("addi_opd", 32'(op_d), 1);
        chk("addi_ops", 32'(op_s), 5);
        chk("addi_imm", 32'(alu_immediate), 1);
        @(negedge clk);
        chk("addi_pc", 32'(prog_addr), 1);
        chk("addi_ret", 32'(retired), 1);
        // WAITH held until the synchronised switch rises
        sw_handshake = 0;
        rst_on(); rom[0] = ins(5, 0, 0); rst_off();
        repeat (10) begin
            @(negedge clk);
            chk("waith_hold_pc", 32'(prog_addr), 0);
            chk("waith_hold_ret", 32'(retired), 0);
        end
        #1 sw_handshake = 1;
        @(negedge clk); chk("waith_e1", 32'(prog_addr), 0);
        @(negedge clk); chk("waith_e2", 32'(prog_addr), 0);
        @(negedge clk); chk("waith_e3", 32'(prog_addr), 1);
        chk("waith_ret", 32'(retired), 1);
        sw_handshake = 0;
        // MUL over four cycles, write only on the last
        rst_on(); rom[0] = ins(3, 2, 3); rst_off();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("mul_func", 32'(alu_func), 1);
            chk("mul_wr", 32'(write_reg), i == 3 ? 1 : 0);
            chk("mul_pc", 32'(prog_addr), 0);
            @(negedge clk);
        end
        chk("mul_done_pc", 32'(prog_addr), 1);
        // JMP 31, wrap to 0, then halt on JMP 0
        rst_on(); rom[0] = ins(7, 0, 31); rst_off();
        @(negedge clk); @(negedge clk);
        chk("jmp_pc31", 32'(prog_addr), 31);
        chk("jmp_ret1", 32'(retired), 1);
        #1 rom[0] = ins(7, 0, 0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("wrap_pc", 32'(prog_addr), 0);
            chk("halt_ret", 32'(retired), k);
        end
        // reset in the second MUL cycle
        rst_on(); rom[0] = ins(3, 2, 3); rst_off();
        @(negedge clk); @(negedge clk);
        #1 nReset = 0;
        #1 chk("rstmul_wr", 32'(write_reg), 0);
        chk("rstmul_pc", 32'(prog_addr), 0);
        chk("rstmul_func", 32'(alu_func), 0);
        rst_off();
        @(negedge clk);
        chk("rstmul_restart_func", 32'(alu_func), 1);
        chk("rstmul_restart_wr", 32'(write_reg), 0);
        // LDSW r7
        rst_on(); rom[0] = ins(4, 7, 0); rst_off();
        @(negedge clk);
        chk("ldsw_wr", 32'(write_reg), 1);
        chk("ldsw_sw", 32'(imm_switches), 1);
        chk("ldsw_func", 32'(alu_func), 2);
        chk("ldsw_opd", 32'(op_d), 7);
        // randomized programs, switch activity and occasional resets
        for (int r = 0; r < 8; r++) begin
            rst_on();
            for (int i = 0; i < 32; i++) rom[i] = ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
            rst_off();
            for (int c = 0; c < 250; c++) begin
                @(negedge clk);
                #1 if ($urandom_range(0, 3) == 0) sw_handshake = ~sw_handshake;
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
